agc_timer: RTL and testbench
============================

// Module: agc_timer
// PURPOSE
// - Timing core of the AGC. Turns the 2.048 MHz CLOCK oscillator into the 12-phase timepulse ring (MT).
// - Sequences GOJAM (restart) after reset and runs the scaler that drives PIPA interrogation (PIPASW/PIPDAT).
// - Accumulates PIPA pulses per axis. Runs on the fast simulation clock SIM_CLK.
// PARAMETERS
// - PRESCALE     10  ticks per scaler increment (1.024 MHz -> 102.4 kHz)
// - SCALER_BITS  17  scaler width
// - PIPA_BITS    15  PIPA accumulator width, two's complement
// PORTS
// - SIM_CLK      in   1            system clock, >=8x CLOCK frequency
// - SIM_RST_n    in   1            reset; asynchronous, active-low
// - CLOCK        in   1            2.048 MHz oscillator, asynchronous to SIM_CLK
// - PIPAXp/PIPAXm/PIPAYp/PIPAYm/PIPAZp/PIPAZm  in  1 each  PIPA pulse inputs
// - MSTP, MSTRT  in   1            monitor stop / start (only with AGC_MONITOR_EN)
// - MT           out  12           one-hot timepulse ring; MT[0]=T01 ... MT[11]=T12
// - MGOJAM       out  1            restart in progress
// - MSTPIT_n     out  1            low = ring halted by monitor
// - PIPASW       out  1            PIPA scan switch (3.2 kHz square wave)
// - PIPDAT       out  1            PIPA data strobe
// - SCALER       out  SCALER_BITS  scaler value
// - PIPAX/PIPAY/PIPAZ  out  PIPA_BITS  per-axis accumulators
// BEHAVIOUR
// - Reset (async, immediate): MT=12'h800 (T12), MGOJAM=1, MSTPIT_n=1, SCALER=0, prescaler=0, PIPA*=0.
//   PIPASW and PIPDAT are 0 (derived from SCALER).
// - CLOCK passes through a 2-flop synchroniser. A tick is every 2nd synchronised CLOCK rising edge.
//   Latency is fixed: CLOCK edge to tick is 2-3 SIM_CLK cycles.
// - Ring: each tick rotates MT one position (T12 wraps to T01). Always exactly one bit set.
//   One MCT = 12 ticks = 24 CLOCK cycles.
// - MGOJAM: held 1 through reset and through the first full MCT after release.
//   Clears on the tick that re-enters T01 (13th tick after release). Stays 0 until the next reset.
// - Scaler: the prescaler counts ticks mod PRESCALE. On its wrap SCALER increments, wrapping at 2^SCALER_BITS.
//   Scaler bits: F01=SCALER[0] (51.2 kHz), F05=SCALER[4].
// - PIPASW = SCALER[4]; period 320 ticks.
// - PIPDAT = (SCALER[4:0]==5'b11000): one pulse per PIPASW period, PRESCALE ticks wide.
// - PIPA inputs are synchronised (2 flops) and rising-edge detected.
//   p edge: +1. m edge: -1. Both edges in the same cycle: no change. Wraps modulo 2^PIPA_BITS.
//   MGOJAM does not clear the accumulators; only reset does.
// - Scaler and PIPA logic run regardless of ring halt.
// CONFIGURATION
// - Macro AGC_MONITOR_EN, defined:
//   - MSTP=1 halts the ring when it reaches T12; MT holds T12 and MSTPIT_n=0.
//   - A synchronised MSTRT rising edge while halted runs exactly one MCT (T01..T12), then halts again.
//   - MSTRT while running is ignored.
//   - MSTP=0 resumes on the next tick.
//   - MGOJAM still clears after one full MCT of advancement.
// - Not defined: MSTP/MSTRT ports absent, MSTPIT_n tied 1, ring free-running.
// STRUCTURE
// - Package agc_timer_pkg: TP_COUNT=12, T12_ONEHOT=12'h800, GOJAM_TICKS=13, PIPDAT_PHASE=5'b11000;
//   typedef tp_t (logic[11:0]).
// - Sub-module agc_pipa_counter (sync + edge detect + up/down accumulator), instantiated 3x (X,Y,Z).
// - Top holds CLOCK sync, tick divider, ring, GOJAM counter, scaler, monitor logic.
// TESTING
// - Release reset, run CLOCK -> MT=T12, MGOJAM=1; after 2 CLOCK rises MT=T01;
//   one-hot each tick; MGOJAM falls on 13th tick.
// - Free run -> MT[0] rises every 24 CLOCK cycles (11.72 us); never 0 or multi-hot.
// - Scaler -> PIPASW period 640 CLOCK cycles (312.5 us);
//   PIPDAT exactly one 10-tick pulse per PIPASW period, while PIPASW=1.
// - PIPA: 3 PIPAXp pulses -> PIPAX=3; then 3 PIPAXm pulses -> 0; simultaneous p+m -> unchanged;
//   one PIPAYm from 0 -> PIPAY=15'h7FFF.
// - Assert SIM_RST_n low mid-MCT (e.g. at T07) -> MT=T12, SCALER=0, PIPA*=0, MGOJAM=1
//   without waiting for a SIM_CLK edge.
// - AGC_MONITOR_EN: MSTP=1 -> ring holds T12, MSTPIT_n=0; one MSTRT pulse -> exactly 12 ticks advance,
//   then holds at T12; MSTP=0 -> resumes.

Source files
------------

// File: rtl/agc_timer_pkg.sv
// agc_timer_pkg: constants and types shared by the AGC timing core.
package agc_timer_pkg;
  localparam int TP_COUNT = 12;
  localparam logic [11:0] T12_ONEHOT = 12'h800;
  localparam int GOJAM_TICKS = 13;
  localparam logic [4:0] PIPDAT_PHASE = 5'b11000;
  typedef logic [TP_COUNT-1:0] tp_t;
  typedef enum logic [1:0] {MON_RUN, MON_HALT, MON_START} mon_state_t;
endpackage

// File: rtl/agc_timer_if.sv
// agc_timer_if: signal bundle between the AGC timing core and its environment.
// slave modport (core side): CLOCK and PIPA pulses in; MT, MGOJAM, MSTPIT_n, PIPASW,
// PIPDAT, SCALER and the PIPA accumulators out. MSTP/MSTRT exist only with AGC_MONITOR_EN.
interface agc_timer_if import agc_timer_pkg::*; #(
  parameter int SCALER_BITS = 17,
  parameter int PIPA_BITS = 15
);
  logic CLOCK;
  logic PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
`ifdef AGC_MONITOR_EN
  logic MSTP, MSTRT;
`endif
  tp_t MT;
  logic MGOJAM, MSTPIT_n, PIPASW, PIPDAT;
  logic [SCALER_BITS-1:0] SCALER;
  logic [PIPA_BITS-1:0] PIPAX, PIPAY, PIPAZ;
  modport slave (
    input CLOCK, PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm,
`ifdef AGC_MONITOR_EN
    input MSTP, MSTRT,
`endif
    output MT, MGOJAM, MSTPIT_n, PIPASW, PIPDAT, SCALER, PIPAX, PIPAY, PIPAZ
  );
  modport master (
    output CLOCK, PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm,
`ifdef AGC_MONITOR_EN
    output MSTP, MSTRT,
`endif
    input MT, MGOJAM, MSTPIT_n, PIPASW, PIPDAT, SCALER, PIPAX, PIPAY, PIPAZ
  );
endinterface

// File: rtl/agc_pipa_counter.sv
// agc_pipa_counter: one PIPA axis; synchronises p/m pulses and keeps a wrapping up/down count.
// Ports: SIM_CLK, SIM_RST_n (async, active-low), p (+1 pulse), m (-1 pulse), acc (count).
module agc_pipa_counter import agc_timer_pkg::*; #(
  parameter int W = 15
) (
  input  logic         SIM_CLK,
  input  logic         SIM_RST_n,
  input  logic         p,
  input  logic         m,
  output logic [W-1:0] acc
);
  logic [2:0] p_sync_q, p_sync_d, m_sync_q, m_sync_d;
  logic [W-1:0] acc_q, acc_d;
  logic p_rise, m_rise;
  always_comb begin
    p_sync_d = {p_sync_q[1:0], p};
    m_sync_d = {m_sync_q[1:0], m};
    p_rise = p_sync_q[1] & ~p_sync_q[2];
    m_rise = m_sync_q[1] & ~m_sync_q[2];
    // coincident up and down pulses cancel
    acc_d = (p_rise == m_rise) ? acc_q : p_rise ? acc_q + W'(1) : acc_q - W'(1);
  end
  always_ff @(posedge SIM_CLK or negedge SIM_RST_n)
    if (!SIM_RST_n) begin
      p_sync_q <= '0;
      m_sync_q <= '0;
      acc_q <= '0;
    end else begin
      p_sync_q <= p_sync_d;
      m_sync_q <= m_sync_d;
      acc_q <= acc_d;
    end
  assign acc = acc_q;
endmodule

// File: rtl/agc_timer.sv
// agc_timer: AGC timing core -- CLOCK sync, 12-phase timepulse ring, GOJAM, scaler, PIPA counts.
// Ports: SIM_CLK, SIM_RST_n (async, active-low), bus (agc_timer_if.slave).
// Optional monitor stop/start ring control is built when AGC_MONITOR_EN is defined.
module agc_timer import agc_timer_pkg::*; #(
  parameter int PRESCALE = 10,
  parameter int SCALER_BITS = 17,
  parameter int PIPA_BITS = 15
) (
  input logic SIM_CLK,
  input logic SIM_RST_n,
  agc_timer_if.slave bus
);
  localparam int PS_W = $clog2(PRESCALE);
  logic [2:0] clk_sync_q, clk_sync_d;
  logic half_q, half_d;
  tp_t mt_q, mt_d;
  logic mgojam_q, mgojam_d;
  logic [3:0] gj_cnt_q, gj_cnt_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [SCALER_BITS-1:0] scaler_q, scaler_d;
  logic clk_rise, tick, adv, mstpit_n;
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], bus.CLOCK};
    clk_rise = clk_sync_q[1] & ~clk_sync_q[2];
    // a tick on every second synchronised CLOCK rise
    half_d = half_q ^ clk_rise;
    tick = clk_rise & half_q;
    mt_d = adv ? {mt_q[TP_COUNT-2:0], mt_q[TP_COUNT-1]} : mt_q;
    // GOJAM drops on the advance that completes the first MCT back into T01
    gj_cnt_d = (adv && mgojam_q) ? gj_cnt_q + 4'd1 : gj_cnt_q;
    mgojam_d = mgojam_q && !(adv && gj_cnt_q == 4'(GOJAM_TICKS - 1));
    ps_d = tick ? ((ps_q == PS_W'(PRESCALE - 1)) ? '0 : ps_q + PS_W'(1)) : ps_q;
    scaler_d = (tick && ps_q == PS_W'(PRESCALE - 1)) ? scaler_q + SCALER_BITS'(1) : scaler_q;
  end
  always_ff @(posedge SIM_CLK or negedge SIM_RST_n)
    if (!SIM_RST_n) begin
      clk_sync_q <= '0;
      half_q <= 1'b0;
      mt_q <= T12_ONEHOT;
      mgojam_q <= 1'b1;
      gj_cnt_q <= '0;
      ps_q <= '0;
      scaler_q <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      half_q <= half_d;
      mt_q <= mt_d;
      mgojam_q <= mgojam_d;
      gj_cnt_q <= gj_cnt_d;
      ps_q <= ps_d;
      scaler_q <= scaler_d;
    end
`ifdef AGC_MONITOR_EN
  mon_state_t st_q, st_d;
  logic [1:0] stp_sync_q, stp_sync_d;
  logic [2:0] strt_sync_q, strt_sync_d;
  logic strt_rise;
  // MON_START is armed by MSTRT and forces one advance out of T12; RUN then
  // carries the ring round to T12, where a still-set MSTP halts it again.
  always_comb begin
    stp_sync_d = {stp_sync_q[0], bus.MSTP};
    strt_sync_d = {strt_sync_q[1:0], bus.MSTRT};
    strt_rise = strt_sync_q[1] & ~strt_sync_q[2];
    st_d = st_q;
    adv = 1'b0;
    case (st_q)
      MON_RUN:
        if (tick) begin
          if (mt_q == T12_ONEHOT && stp_sync_q[1]) st_d = MON_HALT;
          else adv = 1'b1;
        end
      MON_HALT:
        if (strt_rise) st_d = MON_START;
        else if (tick && !stp_sync_q[1]) begin
          adv = 1'b1;
          st_d = MON_RUN;
        end
      MON_START:
        if (tick) begin
          adv = 1'b1;
          st_d = MON_RUN;
        end
      default: st_d = MON_RUN;
    endcase
    mstpit_n = st_q == MON_RUN;
  end
  always_ff @(posedge SIM_CLK or negedge SIM_RST_n)
    if (!SIM_RST_n) begin
      st_q <= MON_RUN;
      stp_sync_q <= '0;
      strt_sync_q <= '0;
    end else begin
      st_q <= st_d;
      stp_sync_q <= stp_sync_d;
      strt_sync_q <= strt_sync_d;
    end
`else
  always_comb begin
    adv = tick;
    mstpit_n = 1'b1;
  end
`endif
  assign bus.MT = mt_q;
  assign bus.MGOJAM = mgojam_q;
  assign bus.MSTPIT_n = mstpit_n;
  assign bus.SCALER = scaler_q;
  assign bus.PIPASW = scaler_q[4];
  assign bus.PIPDAT = scaler_q[4:0] == PIPDAT_PHASE;
  agc_pipa_counter #(.W(PIPA_BITS)) u_pipa_x (.SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .p(bus.PIPAXp), .m(bus.PIPAXm), .acc(bus.PIPAX));
  agc_pipa_counter #(.W(PIPA_BITS)) u_pipa_y (.SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .p(bus.PIPAYp), .m(bus.PIPAYm), .acc(bus.PIPAY));
  agc_pipa_counter #(.W(PIPA_BITS)) u_pipa_z (.SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .p(bus.PIPAZp), .m(bus.PIPAZm), .acc(bus.PIPAZ));
endmodule

// File: tb/tb_agc_timer.sv
// tb_agc_timer: randomized self-checking bench for agc_timer against a tick-count reference model.
module tb_agc_timer;
  logic SIM_CLK = 1'b0;
  logic SIM_RST_n = 1'b0;
  agc_timer_if bus();
  agc_timer dut (.SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .bus(bus));
  always #5 SIM_CLK = ~SIM_CLK;
  int checks = 0;
  int failures = 0;
  int rises, ticks, pos, adv_cnt, step_left;
  bit halted, mstp_m;
  int pipa [3];
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // ring model: pos is the set bit (11 = T12); MSTP halts at T12 unless a start run is pending
  task automatic model_tick();
    ticks++;
    if (pos == 11 && mstp_m && step_left == 0) halted = 1'b1;
    else begin
      pos = (pos + 1) % 12;
      adv_cnt++;
      halted = 1'b0;
      if (step_left > 0) step_left--;
    end
  endtask
  task automatic check_state(string tag);
    int sc;
    sc = (ticks / 10) % 131072;
    chk({tag, ".mt"}, 32'(bus.MT), 32'(1) << pos);
    chk({tag, ".onehot"}, 32'($countones(bus.MT)), 32'd1);
    chk({tag, ".gojam"}, 32'(bus.MGOJAM), 32'(adv_cnt < 13));
    chk({tag, ".mstpit"}, 32'(bus.MSTPIT_n), 32'(!halted));
    chk({tag, ".scaler"}, 32'(bus.SCALER), 32'(sc));
    chk({tag, ".pipasw"}, 32'(bus.PIPASW), 32'((sc / 16) % 2));
    chk({tag, ".pipdat"}, 32'(bus.PIPDAT), 32'(sc % 32 == 24));
  endtask
  task automatic check_pipa(string tag);
    chk({tag, ".x"}, 32'(bus.PIPAX), 32'(pipa[0]));
    chk({tag, ".y"}, 32'(bus.PIPAY), 32'(pipa[1]));
    chk({tag, ".z"}, 32'(bus.PIPAZ), 32'(pipa[2]));
  endtask
  task automatic clock_cycle();
    bus.CLOCK = 1'b1;
    repeat ($urandom_range(4, 6)) @(negedge SIM_CLK);
    bus.CLOCK = 1'b0;
    repeat ($urandom_range(4, 6)) @(negedge SIM_CLK);
    rises++;
    if (rises % 2 == 0) model_tick();
  endtask
  task automatic drive_pipa(int ax, bit p, bit m);
    if (ax == 0) begin bus.PIPAXp = p; bus.PIPAXm = m; end
    else if (ax == 1) begin bus.PIPAYp = p; bus.PIPAYm = m; end
    else begin bus.PIPAZp = p; bus.PIPAZm = m; end
  endtask
  task automatic pipa_pulse(int ax, bit p, bit m);
    drive_pipa(ax, p, m);
    repeat (4) @(negedge SIM_CLK);
    drive_pipa(ax, 1'b0, 1'b0);
    repeat (4) @(negedge SIM_CLK);
    pipa[ax] = (pipa[ax] + int'(p) - int'(m)) & 32'h7fff;
  endtask
  task automatic do_reset();
    SIM_RST_n = 1'b0;
    bus.CLOCK = 1'b0;
    for (int a = 0; a < 3; a++) drive_pipa(a, 1'b0, 1'b0);
`ifdef AGC_MONITOR_EN
    bus.MSTP = 1'b0;
    bus.MSTRT = 1'b0;
`endif
    mstp_m = 1'b0;
    rises = 0; ticks = 0; pos = 11; adv_cnt = 0; step_left = 0; halted = 1'b0;
    pipa = '{0, 0, 0};
    repeat (3) @(negedge SIM_CLK);
    SIM_RST_n = 1'b1;
    repeat (2) @(negedge SIM_CLK);
  endtask
  initial begin
    do_reset();
    check_state("rst");
    check_pipa("rst");
    for (int i = 0; i < 3; i++) pipa_pulse(0, 1'b1, 1'b0);
    check_pipa("xp3");
    for (int i = 0; i < 3; i++) pipa_pulse(0, 1'b0, 1'b1);
    check_pipa("xm3");
    pipa_pulse(0, 1'b1, 1'b1);
    check_pipa("xpm");
    pipa_pulse(1, 1'b0, 1'b1);
    check_pipa("ym");
    for (int i = 0; i < 1400; i++) begin
      clock_cycle();
      check_state("run");
    end
    for (int i = 0; i < 30; i++) begin
      pipa_pulse($urandom_range(0, 2), 1'($urandom), 1'($urandom));
      check_pipa("rnd");
    end
    for (int i = 0; i < 24 && pos != 6; i++) clock_cycle();
    check_state("t07");
    #2 SIM_RST_n = 1'b0;
    #1;
    chk("arst.mt", 32'(bus.MT), 32'h800);
    chk("arst.gojam", 32'(bus.MGOJAM), 32'd1);
    chk("arst.scaler", 32'(bus.SCALER), 32'd0);
    chk("arst.pipx", 32'(bus.PIPAX), 32'd0);
    chk("arst.pipy", 32'(bus.PIPAY), 32'd0);
    chk("arst.pipz", 32'(bus.PIPAZ), 32'd0);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      clock_cycle();
      check_state("rerun");
    end
`ifdef AGC_MONITOR_EN
    bus.MSTP = 1'b1;
    mstp_m = 1'b1;
    repeat (4) @(negedge SIM_CLK);
    for (int i = 0; i < 40; i++) begin
      clock_cycle();
      check_state("stop");
    end
    for (int s = 0; s < 2; s++) begin
      bus.MSTRT = 1'b1;
      repeat (4) @(negedge SIM_CLK);
      bus.MSTRT = 1'b0;
      repeat (4) @(negedge SIM_CLK);
      if (halted) step_left = 12;
      for (int i = 0; i < 36; i++) begin
        clock_cycle();
        check_state("step");
      end
    end
    bus.MSTP = 1'b0;
    mstp_m = 1'b0;
    repeat (4) @(negedge SIM_CLK);
    for (int i = 0; i < 10; i++) begin
      clock_cycle();
      check_state("resume");
    end
    bus.MSTRT = 1'b1;
    repeat (4) @(negedge SIM_CLK);
    bus.MSTRT = 1'b0;
    repeat (4) @(negedge SIM_CLK);
    for (int i = 0; i < 30; i++) begin
      clock_cycle();
      check_state("strt_run");
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
